// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the pong match controller and the surrounding
// top level: pin/collision inputs on one side, ball/score/audio controls
// on the other.
interface pong_match_ctrl_if;
  logic       frame_tick;
  logic       p1_srv;
  logic       p2_srv;
  logic       goal_l;
  logic       goal_r;
  logic [1:0] state;
  logic       ball_run;
  logic       ball_load;
  logic       serve_go;
  logic       serve_side;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       win;
  logic       winner;
  logic       beep_point;

  // Top level / environment side: drives frame, buttons and goals.
  modport master (
    output frame_tick, p1_srv, p2_srv, goal_l, goal_r,
    input  state, ball_run, ball_load, serve_go, serve_side,
    input  score1, score2, win, winner, beep_point
  );

  // Controller side.
  modport slave (
    input  frame_tick, p1_srv, p2_srv, goal_l, goal_r,
    output state, ball_run, ball_load, serve_go, serve_side,
    output score1, score2, win, winner, beep_point
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Match sequencer for pong: serve, rally, point pause and win display,
// plus the two scores. Button and goal levels are edge-detected here so
// a held input only ever acts once.
module pong_match_ctrl #(
  parameter int WIN_SCORE     = 9,
  parameter int POINT_FRAMES  = 30,
  parameter int WIN_FRAMES    = 180,
  parameter int SERVE_TIMEOUT = 600
) (
  input  logic              clk,
  input  logic              rst_n,
  pong_match_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_RALLY = 2'd1,
    S_POINT = 2'd2,
    S_WIN   = 2'd3
  } state_t;

  // A state ends on the tick that brings the counter to its limit, i.e. the
  // tick seen while the counter still holds limit-1.
  localparam logic [9:0] POINT_LAST = 10'(POINT_FRAMES - 1);
  localparam logic [9:0] WIN_LAST   = 10'(WIN_FRAMES - 1);
  localparam logic [9:0] SERVE_LAST = (SERVE_TIMEOUT == 0) ? 10'd0 : 10'(SERVE_TIMEOUT - 1);
  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);

  state_t     r_state;
  logic [9:0] r_frameCnt;
  logic       r_p1Prev;
  logic       r_p2Prev;
  logic       r_goalLPrev;
  logic       r_goalRPrev;
  logic       r_ballRun;
  logic       r_ballLoad;
  logic       r_serveGo;
  logic       r_serveSide;
  logic [3:0] r_score1;
  logic [3:0] r_score2;
  logic       r_win;
  logic       r_winner;
  logic       r_beepPoint;

  logic       w_p1Rise;
  logic       w_p2Rise;
  logic       w_goalLRise;
  logic       w_goalRRise;
  logic       w_serverRise;
  logic       w_serveTimeout;
  logic       w_pointDone;
  logic       w_winDone;
  logic [3:0] w_score1Inc;
  logic [3:0] w_score2Inc;

  assign w_p1Rise       = bus.p1_srv & ~r_p1Prev;
  assign w_p2Rise       = bus.p2_srv & ~r_p2Prev;
  assign w_goalLRise    = bus.goal_l & ~r_goalLPrev;
  assign w_goalRRise    = bus.goal_r & ~r_goalRPrev;
  assign w_serverRise   = r_serveSide ? w_p2Rise : w_p1Rise;
  assign w_serveTimeout = (SERVE_TIMEOUT != 0) && bus.frame_tick && (r_frameCnt == SERVE_LAST);
  assign w_pointDone    = bus.frame_tick && (r_frameCnt == POINT_LAST);
  assign w_winDone      = bus.frame_tick && (r_frameCnt == WIN_LAST);
  assign w_score1Inc    = r_score1 + 4'd1;
  assign w_score2Inc    = r_score2 + 4'd1;

  // Match FSM with edge-detect history, frame counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_SERVE;
      r_frameCnt  <= 10'd0;
      r_p1Prev    <= 1'b1;
      r_p2Prev    <= 1'b1;
      r_goalLPrev <= 1'b1;
      r_goalRPrev <= 1'b1;
      r_ballRun   <= 1'b0;
      r_ballLoad  <= 1'b0;
      r_serveGo   <= 1'b0;
      r_serveSide <= 1'b1;
      r_score1    <= 4'd0;
      r_score2    <= 4'd0;
      r_win       <= 1'b0;
      r_winner    <= 1'b0;
      r_beepPoint <= 1'b0;
    end else begin
      r_p1Prev    <= bus.p1_srv;
      r_p2Prev    <= bus.p2_srv;
      r_goalLPrev <= bus.goal_l;
      r_goalRPrev <= bus.goal_r;
      r_ballLoad  <= 1'b0;
      r_serveGo   <= 1'b0;
      r_beepPoint <= 1'b0;
      case (r_state)
        S_SERVE: begin
          if (w_serverRise || w_serveTimeout) begin
            r_state    <= S_RALLY;
            r_serveGo  <= 1'b1;
            r_ballRun  <= 1'b1;
            r_frameCnt <= 10'd0;
          end else if (bus.frame_tick) begin
            r_frameCnt <= r_frameCnt + 10'd1;
          end
        end
        S_RALLY: begin
          if (w_goalLRise) begin
            r_score2    <= w_score2Inc;
            r_serveSide <= 1'b0;
            r_beepPoint <= 1'b1;
            r_ballRun   <= 1'b0;
            r_frameCnt  <= 10'd0;
            if (w_score2Inc == WIN_VAL) begin
              r_state  <= S_WIN;
              r_win    <= 1'b1;
              r_winner <= 1'b1;
            end else begin
              r_state <= S_POINT;
            end
          end else if (w_goalRRise) begin
            r_score1    <= w_score1Inc;
            r_serveSide <= 1'b1;
            r_beepPoint <= 1'b1;
            r_ballRun   <= 1'b0;
            r_frameCnt  <= 10'd0;
            if (w_score1Inc == WIN_VAL) begin
              r_state  <= S_WIN;
              r_win    <= 1'b1;
              r_winner <= 1'b0;
            end else begin
              r_state <= S_POINT;
            end
          end
        end
        S_POINT: begin
          if (w_pointDone) begin
            r_state    <= S_SERVE;
            r_ballLoad <= 1'b1;
            r_frameCnt <= 10'd0;
          end else if (bus.frame_tick) begin
            r_frameCnt <= r_frameCnt + 10'd1;
          end
        end
        S_WIN: begin
          if (w_winDone) begin
            r_state    <= S_SERVE;
            r_ballLoad <= 1'b1;
            r_win      <= 1'b0;
            r_score1   <= 4'd0;
            r_score2   <= 4'd0;
            r_frameCnt <= 10'd0;
          end else if (bus.frame_tick) begin
            r_frameCnt <= r_frameCnt + 10'd1;
          end
        end
        default: begin
          r_state <= S_SERVE;
        end
      endcase
    end
  end

  assign bus.state      = r_state;
  assign bus.ball_run   = r_ballRun;
  assign bus.ball_load  = r_ballLoad;
  assign bus.serve_go   = r_serveGo;
  assign bus.serve_side = r_serveSide;
  assign bus.score1     = r_score1;
  assign bus.score2     = r_score2;
  assign bus.win        = r_win;
  assign bus.winner     = r_winner;
  assign bus.beep_point = r_beepPoint;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with default parameters
// (WIN_SCORE=9, POINT_FRAMES=30, WIN_FRAMES=180, SERVE_TIMEOUT=600).
module tb_pong_match_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  pong_match_ctrl_if bus();

  pong_match_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Deliver n single-cycle frame ticks separated by an idle cycle; returns
  // just after the edge that sampled the last tick.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
    end
  endtask

  // Reset values; a button held through reset must not serve.
  task automatic test_reset();
    bus.p2_srv = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({bus.state, bus.ball_run, bus.ball_load, bus.serve_go, bus.serve_side,
         bus.win, bus.winner, bus.beep_point} !== 9'b00_0001000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {bus.state, bus.ball_run, bus.ball_load, bus.serve_go, bus.serve_side,
                bus.win, bus.winner, bus.beep_point}, 9'b00_0001000);
    end
    checks++;
    if ({bus.score1, bus.score2} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_scores: got %h expected 00", {bus.score1, bus.score2});
    end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if ({bus.state, bus.serve_go} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL held_through_reset: got %b expected 000", {bus.state, bus.serve_go});
    end
    bus.p2_srv = 1'b0;
    step();
  endtask

  // Only the serving player (p2 after reset) can launch the ball.
  task automatic test_serve();
    bus.p1_srv = 1'b1;
    step();
    bus.p1_srv = 1'b0;
    checks++;
    if ({bus.state, bus.serve_go} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL wrong_server_ignored: got %b expected 000", {bus.state, bus.serve_go});
    end
    step();
    bus.p2_srv = 1'b1;
    step();
    bus.p2_srv = 1'b0;
    checks++;
    if ({bus.state, bus.ball_run, bus.serve_go} !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL serve_launch: got %b expected 0111", {bus.state, bus.ball_run, bus.serve_go});
    end
    step();
    checks++;
    if ({bus.state, bus.ball_run, bus.serve_go} !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL serve_go_one_cycle: got %b expected 0110", {bus.state, bus.ball_run, bus.serve_go});
    end
  endtask

  // Player 1 scores, POINT lasts exactly 30 ticks, goals in POINT ignored.
  task automatic test_point();
    bus.goal_r = 1'b1;
    step();
    bus.goal_r = 1'b0;
    checks++;
    if (bus.score1 !== 4'd1) begin
      errors++;
      $display("[TB] FAIL point_score1: got %0d expected 1", bus.score1);
    end
    checks++;
    if ({bus.state, bus.serve_side, bus.beep_point, bus.ball_run} !== 5'b10110) begin
      errors++;
      $display("[TB] FAIL point_entry: got %b expected 10110",
               {bus.state, bus.serve_side, bus.beep_point, bus.ball_run});
    end
    step();
    checks++;
    if (bus.beep_point !== 1'b0) begin
      errors++;
      $display("[TB] FAIL beep_one_cycle: got %b expected 0", bus.beep_point);
    end
    bus.goal_l = 1'b1;
    step();
    bus.goal_l = 1'b0;
    checks++;
    if ({bus.state, bus.score1, bus.score2} !== {2'd2, 4'd1, 4'd0}) begin
      errors++;
      $display("[TB] FAIL goal_in_point_ignored: got %h expected %h",
               {bus.state, bus.score1, bus.score2}, {2'd2, 4'd1, 4'd0});
    end
    ticks(29);
    checks++;
    if (bus.state !== 2'd2) begin
      errors++;
      $display("[TB] FAIL point_29_ticks: got state %0d expected 2", bus.state);
    end
    step();
    ticks(1);
    checks++;
    if ({bus.state, bus.ball_load} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL point_end_load: got %b expected 001", {bus.state, bus.ball_load});
    end
    step();
    checks++;
    if (bus.ball_load !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ball_load_one_cycle: got %b expected 0", bus.ball_load);
    end
  endtask

  // Simultaneous goal rises: only the left goal (player 2) counts.
  task automatic test_simul_goals();
    bus.p2_srv = 1'b1;
    step();
    bus.p2_srv = 1'b0;
    step();
    bus.goal_l = 1'b1;
    bus.goal_r = 1'b1;
    step();
    bus.goal_l = 1'b0;
    bus.goal_r = 1'b0;
    checks++;
    if ({bus.state, bus.serve_side, bus.score1, bus.score2} !== {2'd2, 1'b0, 4'd1, 4'd1}) begin
      errors++;
      $display("[TB] FAIL simul_goals: got %b expected %b",
               {bus.state, bus.serve_side, bus.score1, bus.score2}, {2'd2, 1'b0, 4'd1, 4'd1});
    end
    ticks(30);
    step();
    checks++;
    if ({bus.state, bus.serve_side} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL serve_after_simul: got %b expected 000", {bus.state, bus.serve_side});
    end
  endtask

  // A p1 button held across POINT->SERVE must be released before serving.
  task automatic test_held_button();
    bus.p1_srv = 1'b1;
    step();
    checks++;
    if ({bus.state, bus.serve_go} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL p1_serve: got %b expected 011", {bus.state, bus.serve_go});
    end
    step();
    bus.goal_l = 1'b1;
    step();
    bus.goal_l = 1'b0;
    ticks(30);
    step();
    step();
    checks++;
    if ({bus.state, bus.serve_go, bus.score2} !== {2'd0, 1'b0, 4'd2}) begin
      errors++;
      $display("[TB] FAIL held_across_point: got %b expected %b",
               {bus.state, bus.serve_go, bus.score2}, {2'd0, 1'b0, 4'd2});
    end
    bus.p1_srv = 1'b0;
    step();
    bus.p1_srv = 1'b1;
    step();
    bus.p1_srv = 1'b0;
    checks++;
    if ({bus.state, bus.serve_go} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL repress_serves: got %b expected 011", {bus.state, bus.serve_go});
    end
    step();
    // Player 2 scores six more points, reaching 8.
    for (int i = 0; i < 6; i++) begin
      bus.goal_l = 1'b1;
      step();
      bus.goal_l = 1'b0;
      step();
      ticks(30);
      step();
      bus.p1_srv = 1'b1;
      step();
      bus.p1_srv = 1'b0;
      step();
    end
    checks++;
    if ({bus.state, bus.score1, bus.score2} !== {2'd1, 4'd1, 4'd8}) begin
      errors++;
      $display("[TB] FAIL reach_eight: got %h expected %h",
               {bus.state, bus.score1, bus.score2}, {2'd1, 4'd1, 4'd8});
    end
  endtask

  // Ninth point wins; WIN lasts 180 ticks then clears the match.
  task automatic test_win();
    bus.goal_l = 1'b1;
    step();
    bus.goal_l = 1'b0;
    checks++;
    if ({bus.state, bus.win, bus.winner, bus.beep_point, bus.score2} !== {2'd3, 3'b111, 4'd9}) begin
      errors++;
      $display("[TB] FAIL win_entry: got %b expected %b",
               {bus.state, bus.win, bus.winner, bus.beep_point, bus.score2}, {2'd3, 3'b111, 4'd9});
    end
    step();
    bus.goal_r = 1'b1;
    step();
    bus.goal_r = 1'b0;
    checks++;
    if (bus.score1 !== 4'd1) begin
      errors++;
      $display("[TB] FAIL goal_in_win_ignored: got %0d expected 1", bus.score1);
    end
    ticks(179);
    checks++;
    if ({bus.state, bus.win} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL win_179_ticks: got %b expected 111", {bus.state, bus.win});
    end
    step();
    ticks(1);
    checks++;
    if ({bus.state, bus.win, bus.ball_load, bus.serve_side, bus.score1, bus.score2}
        !== {2'd0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL win_restart: got %b expected %b",
               {bus.state, bus.win, bus.ball_load, bus.serve_side, bus.score1, bus.score2},
               {2'd0, 1'b0, 1'b1, 1'b0, 8'h00});
    end
  endtask

  // With no press, the serve happens on exactly the 600th tick.
  task automatic test_auto_serve();
    step();
    ticks(599);
    checks++;
    if ({bus.state, bus.serve_go} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL auto_599_ticks: got %b expected 000", {bus.state, bus.serve_go});
    end
    step();
    ticks(1);
    checks++;
    if ({bus.state, bus.ball_run, bus.serve_go} !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL auto_serve: got %b expected 0111", {bus.state, bus.ball_run, bus.serve_go});
    end
  endtask

  // One-cycle reset in RALLY and then in WIN restores reset values.
  task automatic test_reset_mid();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({bus.state, bus.ball_run, bus.ball_load, bus.serve_go, bus.serve_side,
         bus.win, bus.winner, bus.beep_point} !== 9'b00_0001000) begin
      errors++;
      $display("[TB] FAIL reset_in_rally: got %b expected %b",
               {bus.state, bus.ball_run, bus.ball_load, bus.serve_go, bus.serve_side,
                bus.win, bus.winner, bus.beep_point}, 9'b00_0001000);
    end
    step();
    // Player 1 scores nine straight points, p2 serving each time.
    for (int i = 0; i < 9; i++) begin
      bus.p2_srv = 1'b1;
      step();
      bus.p2_srv = 1'b0;
      step();
      bus.goal_r = 1'b1;
      step();
      bus.goal_r = 1'b0;
      step();
      if (i < 8) begin
        ticks(30);
        step();
      end
    end
    checks++;
    if ({bus.state, bus.win, bus.winner, bus.score1, bus.score2} !== {2'd3, 2'b10, 4'd9, 4'd0}) begin
      errors++;
      $display("[TB] FAIL p1_wins: got %b expected %b",
               {bus.state, bus.win, bus.winner, bus.score1, bus.score2}, {2'd3, 2'b10, 4'd9, 4'd0});
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({bus.state, bus.ball_run, bus.ball_load, bus.serve_go, bus.serve_side,
         bus.win, bus.winner, bus.beep_point, bus.score1, bus.score2} !== {9'b00_0001000, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_in_win: got %b expected %b",
               {bus.state, bus.ball_run, bus.ball_load, bus.serve_go, bus.serve_side,
                bus.win, bus.winner, bus.beep_point, bus.score1, bus.score2}, {9'b00_0001000, 8'h00});
    end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    errors         = 0;
    checks         = 0;
    rst_n          = 1'b0;
    bus.frame_tick = 1'b0;
    bus.p1_srv     = 1'b0;
    bus.p2_srv     = 1'b0;
    bus.goal_l     = 1'b0;
    bus.goal_r     = 1'b0;
    test_reset();
    test_serve();
    test_point();
    test_simul_goals();
    test_held_button();
    test_win();
    test_auto_serve();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
